// File: rtl/idct_block_prefetcher.sv
// idct_block_prefetcher: streams BLOCK_DIM x BLOCK_DIM coefficient blocks (Y, then U,
// then V, each plane row-major by block) from SRAM into a ping-pong pair of DP-RAM
// banks. The IDCT stage drains one bank while the other fills; the valid/ack pair on
// the Block_* outputs releases banks strictly in the order they were filled.
module idct_block_prefetcher #(
  parameter int BLOCK_DIM    = 8,
  parameter int DATA_W       = 16,
  parameter int BUF_W        = 32,
  parameter int SRAM_AW      = 18,
  parameter int SRAM_LATENCY = 2,
  parameter int PRE_BASE     = 76800,
  parameter int Y_ROW_WORDS  = 320,
  parameter int IMG_ROWS     = 240
) (
  input  logic                                        Clock,
  input  logic                                        Reset,
  input  logic                                        Start,
  output logic                                        Busy,
  output logic                                        Done,
  output logic [SRAM_AW-1:0]                          SRAM_address,
  input  logic [DATA_W-1:0]                           SRAM_read_data,
  output logic                                        SRAM_we_n,
  output logic [$clog2(2*BLOCK_DIM*BLOCK_DIM)-1:0]    Buf_address,
  output logic [BUF_W-1:0]                            Buf_write_data,
  output logic                                        Buf_we,
  output logic                                        Block_valid,
  output logic                                        Block_bank,
  output logic [1:0]                                  Block_plane,
  output logic [5:0]                                  Block_col,
  output logic [4:0]                                  Block_row,
  input  logic                                        Block_ack
);

  localparam int BLK_WORDS    = BLOCK_DIM * BLOCK_DIM;
  localparam int IDX_W        = $clog2(BLK_WORDS);
  localparam int DIM_W        = $clog2(BLOCK_DIM);
  localparam int BUF_AW       = $clog2(2 * BLK_WORDS);
  localparam int DR_W         = $clog2(SRAM_LATENCY + 1);
  localparam int UV_ROW_WORDS = Y_ROW_WORDS / 2;
  localparam int U_BASE       = PRE_BASE + Y_ROW_WORDS * IMG_ROWS;
  localparam int V_BASE       = U_BASE + UV_ROW_WORDS * IMG_ROWS;
  localparam int Y_BCOLS      = Y_ROW_WORDS / BLOCK_DIM;
  localparam int UV_BCOLS     = UV_ROW_WORDS / BLOCK_DIM;
  localparam int BROWS        = IMG_ROWS / BLOCK_DIM;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BANK = 3'd1,
    S_ISSUE     = 3'd2,
    S_DRAIN     = 3'd3,
    S_PUBLISH   = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  // Signed coefficient widened to the DP-RAM word.
  function automatic logic [BUF_W-1:0] sign_extend(input logic [DATA_W-1:0] d);
    return {{(BUF_W-DATA_W){d[DATA_W-1]}}, d};
  endfunction

  state_t             state_r;
  logic [1:0]         plane_r;
  logic [5:0]         bcol_r;
  logic [4:0]         brow_r;
  logic [IDX_W-1:0]   idx_r;
  logic [DR_W-1:0]    drain_r;
  logic               wr_bank_r;
  logic               rd_bank_r;
  logic [1:0]         full_r;
  logic [1:0]         meta_plane_r [2];
  logic [5:0]         meta_col_r   [2];
  logic [4:0]         meta_row_r   [2];
  logic [SRAM_LATENCY-1:0] pipe_vld_r;
  logic [BUF_AW-1:0]  pipe_addr_r  [SRAM_LATENCY];

  logic [SRAM_AW-1:0] plane_base_s;
  logic [SRAM_AW-1:0] stride_s;
  logic [SRAM_AW-1:0] block_base_s;
  logic [SRAM_AW-1:0] addr_next_s;
  logic [IDX_W-1:0]   idx_nx_s;
  logic               col_last_s;
  logic               row_last_s;
  logic               ack_take_s;
  logic [1:0]         full_nx_s;
  logic               rd_bank_nx_s;

  // Plane geometry and SRAM address of the current block and of the next read.
  always_comb begin
    case (plane_r)
      2'd0: begin
        plane_base_s = SRAM_AW'(PRE_BASE);
        stride_s     = SRAM_AW'(Y_ROW_WORDS);
        col_last_s   = (bcol_r == 6'(Y_BCOLS - 1));
      end
      2'd1: begin
        plane_base_s = SRAM_AW'(U_BASE);
        stride_s     = SRAM_AW'(UV_ROW_WORDS);
        col_last_s   = (bcol_r == 6'(UV_BCOLS - 1));
      end
      default: begin
        plane_base_s = SRAM_AW'(V_BASE);
        stride_s     = SRAM_AW'(UV_ROW_WORDS);
        col_last_s   = (bcol_r == 6'(UV_BCOLS - 1));
      end
    endcase
    row_last_s   = (brow_r == 5'(BROWS - 1));
    block_base_s = plane_base_s
                 + SRAM_AW'(brow_r) * (SRAM_AW'(BLOCK_DIM) * stride_s)
                 + SRAM_AW'(bcol_r) * SRAM_AW'(BLOCK_DIM);
    idx_nx_s     = idx_r + IDX_W'(1);
    addr_next_s  = block_base_s
                 + SRAM_AW'(idx_nx_s[IDX_W-1:DIM_W]) * stride_s
                 + SRAM_AW'(idx_nx_s[DIM_W-1:0]);
  end

  // Bank occupancy next state: a release and a publish in the same cycle both apply.
  always_comb begin
    ack_take_s   = Block_ack & Block_valid;
    full_nx_s    = (full_r & ~(ack_take_s ? (2'b01 << rd_bank_r) : 2'b00))
                 | ((state_r == S_PUBLISH) ? (2'b01 << wr_bank_r) : 2'b00);
    rd_bank_nx_s = rd_bank_r ^ ack_take_s;
  end

  // Fetch sequencer: waits for an empty bank, issues one read per cycle, drains, publishes.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r         <= S_IDLE;
      Busy            <= 1'b0;
      Done            <= 1'b0;
      SRAM_address    <= '0;
      SRAM_we_n       <= 1'b1;
      plane_r         <= 2'd0;
      bcol_r          <= 6'd0;
      brow_r          <= 5'd0;
      idx_r           <= '0;
      drain_r         <= '0;
      wr_bank_r       <= 1'b0;
      meta_plane_r[0] <= 2'd0;
      meta_plane_r[1] <= 2'd0;
      meta_col_r[0]   <= 6'd0;
      meta_col_r[1]   <= 6'd0;
      meta_row_r[0]   <= 5'd0;
      meta_row_r[1]   <= 5'd0;
    end else begin
      Done      <= 1'b0;
      SRAM_we_n <= 1'b1;
      case (state_r)
        S_IDLE: begin
          if (Start) begin
            Busy    <= 1'b1;
            plane_r <= 2'd0;
            bcol_r  <= 6'd0;
            brow_r  <= 5'd0;
            state_r <= S_WAIT_BANK;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_WAIT_BANK: begin
          // Only an empty bank is neither full nor presented, so it is safe to overwrite.
          if (!full_r[wr_bank_r]) begin
            meta_plane_r[wr_bank_r] <= plane_r;
            meta_col_r[wr_bank_r]   <= bcol_r;
            meta_row_r[wr_bank_r]   <= brow_r;
            idx_r                   <= '0;
            SRAM_address            <= block_base_s;
            state_r                 <= S_ISSUE;
          end else begin
            state_r <= S_WAIT_BANK;
          end
        end
        S_ISSUE: begin
          if (idx_r == IDX_W'(BLK_WORDS - 1)) begin
            drain_r <= '0;
            state_r <= S_DRAIN;
          end else begin
            idx_r        <= idx_nx_s;
            SRAM_address <= addr_next_s;
          end
        end
        S_DRAIN: begin
          if (drain_r == DR_W'(SRAM_LATENCY - 1)) begin
            state_r <= S_PUBLISH;
          end else begin
            drain_r <= drain_r + DR_W'(1);
          end
        end
        S_PUBLISH: begin
          wr_bank_r <= ~wr_bank_r;
          if (!col_last_s) begin
            bcol_r  <= bcol_r + 6'd1;
            state_r <= S_WAIT_BANK;
          end else if (!row_last_s) begin
            bcol_r  <= 6'd0;
            brow_r  <= brow_r + 5'd1;
            state_r <= S_WAIT_BANK;
          end else if (plane_r != 2'd2) begin
            bcol_r  <= 6'd0;
            brow_r  <= 5'd0;
            plane_r <= plane_r + 2'd1;
            state_r <= S_WAIT_BANK;
          end else begin
            state_r <= S_FINISH;
          end
        end
        S_FINISH: begin
          if (full_r == 2'b00) begin
            Done    <= 1'b1;
            Busy    <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            state_r <= S_FINISH;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Bank handshake: present the oldest full bank together with its block coordinates.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      full_r      <= 2'b00;
      rd_bank_r   <= 1'b0;
      Block_valid <= 1'b0;
      Block_bank  <= 1'b0;
      Block_plane <= 2'd0;
      Block_col   <= 6'd0;
      Block_row   <= 5'd0;
    end else begin
      full_r      <= full_nx_s;
      rd_bank_r   <= rd_bank_nx_s;
      Block_valid <= full_nx_s[rd_bank_nx_s];
      Block_bank  <= rd_bank_nx_s;
      Block_plane <= meta_plane_r[rd_bank_nx_s];
      Block_col   <= meta_col_r[rd_bank_nx_s];
      Block_row   <= meta_row_r[rd_bank_nx_s];
    end
  end

  // Write-side delay line: aligns each buffer address with its returning SRAM word.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pipe_vld_r <= '0;
      for (int i = 0; i < SRAM_LATENCY; i++) begin
        pipe_addr_r[i] <= '0;
      end
    end else begin
      pipe_vld_r[0]  <= (state_r == S_ISSUE);
      pipe_addr_r[0] <= {wr_bank_r, idx_r};
      for (int i = 1; i < SRAM_LATENCY; i++) begin
        pipe_vld_r[i]  <= pipe_vld_r[i-1];
        pipe_addr_r[i] <= pipe_addr_r[i-1];
      end
    end
  end

  assign Buf_we         = pipe_vld_r[SRAM_LATENCY-1];
  assign Buf_address    = pipe_addr_r[SRAM_LATENCY-1];
  assign Buf_write_data = Buf_we ? sign_extend(SRAM_read_data) : {BUF_W{1'b0}};

endmodule
